// File: rtl/controle_direcao.sv
// controle_direcao: debounced turn keys and periodic step pulse for a snake heading
module controle_direcao #(
  parameter int DEBOUNCE_CICLOS = 250000,
  parameter int PERIODO_PASSO   = 1000000
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  input  logic [3:0] KEY,
  input  logic       pausa,
  input  logic       reiniciar,
  output logic [1:0] sentido,
  output logic       passo,
  output logic       giro_h,
  output logic       giro_ah,
  output logic [3:0] teclas_estaveis
);
  localparam int DW = DEBOUNCE_CICLOS > 1 ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam int PW = PERIODO_PASSO > 1 ? $clog2(PERIODO_PASSO) : 1;
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CICLOS - 1);
  localparam logic [PW-1:0] P_MAX = PW'(PERIODO_PASSO - 1);
  logic [3:0] key_meta_q, key_sync_q, est_q, est_d, est_dly_q;
  logic [DW-1:0] db_cnt_q [4];
  logic [DW-1:0] db_cnt_d [4];
  logic [PW-1:0] passo_cnt_q, passo_cnt_d;
  logic [1:0] sentido_q, sentido_d;
  logic lock_q, lock_d, giro_h_q, giro_h_d, giro_ah_q, giro_ah_d;
  logic ev_h, ev_ah, aceita;
  assign ev_h = est_dly_q[2] & ~est_q[2];
  assign ev_ah = est_dly_q[3] & ~est_q[3];
  assign passo = ~pausa & (passo_cnt_q == P_MAX);
  assign aceita = ~pausa & ~lock_q & (ev_h ^ ev_ah);
  assign sentido = sentido_q;
  assign giro_h = giro_h_q;
  assign giro_ah = giro_ah_q;
  assign teclas_estaveis = est_q;
  // debounce: a level is accepted only after it differs from the stable copy for DEBOUNCE_CICLOS cycles
  always_comb begin
    db_cnt_d = db_cnt_q;
    est_d = est_q;
    for (int i = 0; i < 4; i++) begin
      if (key_sync_q[i] == est_q[i]) db_cnt_d[i] = '0;
      else if (db_cnt_q[i] == DB_MAX) begin
        db_cnt_d[i] = '0;
        est_d[i] = key_sync_q[i];
      end else db_cnt_d[i] = db_cnt_q[i] + DW'(1);
    end
  end
  // step timing, turn acceptance with one-turn-per-step lockout, round restart
  always_comb begin
    passo_cnt_d = pausa ? passo_cnt_q : (passo_cnt_q == P_MAX ? '0 : passo_cnt_q + PW'(1));
    sentido_d = aceita ? (ev_h ? sentido_q + 2'd1 : sentido_q - 2'd1) : sentido_q;
    giro_h_d = aceita & ev_h;
    giro_ah_d = aceita & ev_ah;
    lock_d = aceita | (lock_q & ~passo);
    if (reiniciar) begin
      passo_cnt_d = '0;
      sentido_d = 2'd0;
      giro_h_d = 1'b0;
      giro_ah_d = 1'b0;
      lock_d = 1'b0;
    end
  end
  // synchronizers and debounce state; untouched by reiniciar
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      key_meta_q <= 4'hF;
      key_sync_q <= 4'hF;
      est_q <= 4'hF;
      est_dly_q <= 4'hF;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      key_meta_q <= KEY;
      key_sync_q <= key_meta_q;
      est_q <= est_d;
      est_dly_q <= est_q;
      db_cnt_q <= db_cnt_d;
    end
  end
  // heading, pulses, step counter and lockout registers
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      passo_cnt_q <= '0;
      sentido_q <= 2'd0;
      lock_q <= 1'b0;
      giro_h_q <= 1'b0;
      giro_ah_q <= 1'b0;
    end else begin
      passo_cnt_q <= passo_cnt_d;
      sentido_q <= sentido_d;
      lock_q <= lock_d;
      giro_h_q <= giro_h_d;
      giro_ah_q <= giro_ah_d;
    end
  end
endmodule

// File: tb/tb_controle_direcao.sv
// tb_controle_direcao: directed checks of debounce, turning, lockout, pause and restart
module tb_controle_direcao;
  logic clk = 1'b0, reset, pausa, reiniciar;
  logic [3:0] KEY, teclas_estaveis;
  logic [1:0] sentido;
  logic passo, giro_h, giro_ah;
  int checks = 0, failures = 0;
  int n_h = 0, n_ah = 0, n_passo = 0;
  int h0, a0, p0, n, first, last, cnt;
  logic ok;
  controle_direcao #(.DEBOUNCE_CICLOS(4), .PERIODO_PASSO(8)) dut (
    .VGA_CLK(clk), .reset(reset), .KEY(KEY), .pausa(pausa), .reiniciar(reiniciar),
    .sentido(sentido), .passo(passo), .giro_h(giro_h), .giro_ah(giro_ah),
    .teclas_estaveis(teclas_estaveis)
  );
  always #5 clk = ~clk;
  // pulse tally: values seen just before each rising edge belong to the cycle that ends there
  always @(posedge clk) begin
    n_h += int'(giro_h);
    n_ah += int'(giro_ah);
    n_passo += int'(passo);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic wait_passo();
    int i;
    i = 0;
    do begin step(); i++; end while (!passo && i < 20);
    chk("wait_passo", passo, 1);
  endtask
  task automatic steps_to_passo(output int k);
    k = 0;
    do begin step(); k++; end while (!passo && k < 20);
  endtask
  task automatic press(input int k, input int hold);
    KEY[k] = 1'b0;
    repeat (hold) step();
    KEY[k] = 1'b1;
    repeat (hold) step();
  endtask
  initial begin
    reset = 1'b1; KEY = 4'hF; pausa = 1'b0; reiniciar = 1'b0;
    repeat (3) step();
    chk("rst_sentido", sentido, 0);
    chk("rst_passo", passo, 0);
    chk("rst_giro_h", giro_h, 0);
    chk("rst_giro_ah", giro_ah, 0);
    chk("rst_teclas", teclas_estaveis, 4'hF);
    reset = 1'b0;
    n = 0; first = -1; last = -1;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (passo) begin
        n++;
        if (first < 0) first = i;
        else chk("passo_gap", i - last, 8);
        last = i;
      end
    end
    chk("idle_passo_count", n, 3);
    chk("idle_first_passo", first, 7);
    chk("idle_sentido", sentido, 0);
    chk("idle_teclas", teclas_estaveis, 4'hF);
    wait_passo();
    h0 = n_h; a0 = n_ah;
    press(2, 10);
    repeat (4) step();
    chk("cw_hold_pulses", n_h - h0, 1);
    chk("cw_hold_no_ah", n_ah - a0, 0);
    chk("cw_hold_sentido", sentido, 1);
    h0 = n_h; ok = 1'b1;
    KEY[2] = 1'b0; step(); step(); KEY[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      ok &= (teclas_estaveis === 4'hF);
    end
    chk("glitch_teclas_stable", ok, 1);
    chk("glitch_no_pulse", n_h - h0, 0);
    chk("glitch_sentido", sentido, 1);
    for (int j = 0; j < 5; j++) begin
      wait_passo();
      a0 = n_ah;
      press(3, 8);
      step();
      chk("ah_pulse", n_ah - a0, 1);
      chk("ah_sentido", sentido, (j == 0) ? 0 : 4 - j);
    end
    wait_passo();
    step(); step();
    h0 = n_h;
    KEY[2] = 1'b0; repeat (4) step();
    KEY[2] = 1'b1; repeat (4) step();
    KEY[2] = 1'b0; repeat (4) step();
    KEY[2] = 1'b1; repeat (8) step();
    chk("lockout_one_pulse", n_h - h0, 1);
    chk("lockout_sentido", sentido, 1);
    press(2, 8);
    step();
    chk("after_passo_pulses", n_h - h0, 2);
    chk("after_passo_sentido", sentido, 2);
    wait_passo();
    h0 = n_h; a0 = n_ah;
    KEY[3:2] = 2'b00; repeat (8) step();
    KEY[3:2] = 2'b11; repeat (8) step();
    chk("both_no_h", n_h - h0, 0);
    chk("both_no_ah", n_ah - a0, 0);
    chk("both_sentido", sentido, 2);
    wait_passo();
    repeat (3) step();
    pausa = 1'b1;
    p0 = n_passo; h0 = n_h;
    KEY[2] = 1'b0; repeat (8) step();
    chk("pausa_debounce_runs", teclas_estaveis[2], 0);
    KEY[2] = 1'b1; repeat (8) step();
    pausa = 1'b0;
    chk("pausa_no_passo", n_passo - p0, 0);
    chk("pausa_no_turn", n_h - h0, 0);
    chk("pausa_sentido", sentido, 2);
    steps_to_passo(cnt);
    chk("pausa_counter_frozen", cnt, 5);
    KEY[0] = 1'b0;
    repeat (8) step();
    chk("key0_debounced", teclas_estaveis, 4'hE);
    wait_passo();
    repeat (3) step();
    reiniciar = 1'b1;
    step();
    chk("rein_sentido", sentido, 0);
    chk("rein_teclas", teclas_estaveis, 4'hE);
    chk("rein_passo", passo, 0);
    reiniciar = 1'b0;
    steps_to_passo(cnt);
    chk("rein_counter_zero", cnt, 7);
    press(2, 8);
    step();
    chk("pre_reset_sentido", sentido, 1);
    wait_passo();
    #2 reset = 1'b1;
    #1;
    chk("async_sentido", sentido, 0);
    chk("async_passo", passo, 0);
    chk("async_teclas", teclas_estaveis, 4'hF);
    chk("async_giro", {giro_h, giro_ah}, 0);
    KEY[3] = 1'b0;
    repeat (2) step();
    a0 = n_ah;
    reset = 1'b0;
    repeat (5) step();
    chk("rel_mid_press_teclas", teclas_estaveis[3], 1);
    chk("rel_mid_press_no_event", n_ah - a0, 0);
    repeat (6) step();
    chk("rel_mid_press_late_event", n_ah - a0, 1);
    chk("rel_mid_press_sentido", sentido, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/controle_direcao.md
CONTROLE_DIRECAO -- requirements
Module: controle_direcao

Interface
REQ-001 SHALL have parameter DEBOUNCE_CICLOS, default 250000, meaning cycles a key level must hold before it is accepted (10 ms at 25 MHz).
REQ-002 SHALL have parameter PERIODO_PASSO, default 1000000, meaning VGA_CLK cycles per movement step.
REQ-003 SHALL have port VGA_CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port KEY  input  4  raw push-buttons, active-low, asynchronous to VGA_CLK; KEY[3] = anti-clockwise, KEY[2] = clockwise, KEY[1:0] = debounced only.
REQ-006 SHALL have port pausa  input  1  synchronous; freezes stepping and turning (driven by game-over).
REQ-007 SHALL have port reiniciar  input  1  synchronous round restart.
REQ-008 SHALL have port sentido  output  2  registered heading: 0 right, 1 down, 2 left, 3 up.
REQ-009 SHALL have port passo  output  1  one-cycle pulse, one per movement step.
REQ-010 SHALL have port giro_h  output  1  one-cycle pulse, clockwise turn accepted.
REQ-011 SHALL have port giro_ah  output  1  one-cycle pulse, anti-clockwise turn accepted.
REQ-012 SHALL have port teclas_estaveis  output  4  debounced key levels, active-low.

Function
REQ-013 Each KEY bit SHALL pass through a 2-flop synchronizer before any other use; synchronizer flops reset to 1.
REQ-014 Per-key debounce: counter SHALL clear whenever the synchronized level equals teclas_estaveis[i], and SHALL increment while they differ.
REQ-015 teclas_estaveis[i] SHALL take the synchronized level in the cycle the counter reaches DEBOUNCE_CICLOS-1, and the counter SHALL clear in that cycle.
REQ-016 Glitches shorter than DEBOUNCE_CICLOS cycles SHALL NOT change teclas_estaveis.
REQ-017 A press event SHALL be a 1->0 transition of teclas_estaveis[3] or [2], detected against a one-cycle-delayed copy; a release SHALL produce no event.
REQ-018 Clockwise press event SHALL give sentido <= sentido+1 mod 4 and giro_h = 1, both in the cycle after the event.
REQ-019 Anti-clockwise press event SHALL give sentido <= sentido-1 mod 4 and giro_ah = 1, both in the cycle after the event.
REQ-020 Press events on KEY[3] and KEY[2] in the same cycle SHALL cancel: no turn, no pulse.
REQ-021 Once one turn is accepted, a lockout flag SHALL set, and further press events SHALL be ignored and dropped, not queued, until the next passo pulse clears the flag.
REQ-022 A press event in the same cycle as passo SHALL be accepted only if lockout was clear before that cycle; lockout is then set again.
REQ-023 Step counter SHALL count 0..PERIODO_PASSO-1 and wrap; passo SHALL be 1 for exactly the cycle in which the counter value is PERIODO_PASSO-1.
REQ-024 While pausa=1: step counter SHALL hold, passo SHALL be 0, press events SHALL be dropped, sentido SHALL hold; debouncing SHALL continue.
REQ-025 reiniciar=1 SHALL have priority over pausa and key events, and SHALL set sentido=0, step counter=0, lockout=0, passo=giro_h=giro_ah=0 on the next edge.
REQ-026 reiniciar SHALL leave the synchronizers, debounce counters and teclas_estaveis unaffected.
REQ-027 Counter widths SHALL be derived from the parameters with $clog2; no overflow is permitted at the default values.

Reset
REQ-028 While reset=1, all state SHALL be held at reset values, independent of VGA_CLK: sentido=0, passo=0, giro_h=0, giro_ah=0, teclas_estaveis=4'b1111, all counters=0, lockout=0, delayed copies=1.
REQ-029 Reset release mid-press SHALL NOT generate a press event until a full debounce interval has elapsed.

Verification
Scenarios use DEBOUNCE_CICLOS=4 and PERIODO_PASSO=8.
REQ-030 Reset then idle 20 cycles -> passo pulses every 8 cycles, sentido=0, teclas_estaveis=1111.
REQ-031 KEY[2] held low 10 cycles, starting with lockout clear -> exactly one giro_h pulse, sentido 0->1; a 2-cycle low glitch on KEY[2] -> no change.
REQ-032 Four anti-clockwise presses, each separated by at least one passo pulse, from sentido=0 -> sentido 3, 2, 1, 0 (wrap-around checked).
REQ-033 Two clockwise presses within one step period -> only the first is accepted (sentido +1), second dropped; after the next passo a third press is accepted.
REQ-034 KEY[3] and KEY[2] pressed in the same cycle -> no pulse and sentido unchanged; pausa=1 with a press -> counter frozen, no passo, no turn.
REQ-035 reiniciar pulse with sentido=2 -> sentido=0 and counter=0 next cycle, teclas_estaveis unchanged; async reset asserted mid-period -> outputs at reset values immediately, without a clock edge.
